// File: rtl/mem_fu_sequencer_pkg.sv
// Shared RV32I types for the load/store path: reservation entry, CDB payload,
// memory-sequencer states and load/store funct3 encodings.
package rv32i_types;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned PR_WIDTH   = 6;
  localparam int unsigned ROB_WIDTH  = 4;
  localparam int unsigned AR_WIDTH   = 5;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone,
    StDrain
  } mem_seq_state_t;

  typedef struct packed {
    logic                  ls_valid;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [PR_WIDTH-1:0]   addr;      // physical source holding the base address
    logic [PR_WIDTH-1:0]   data;      // physical source holding store data
    logic [DATA_WIDTH-1:0] offset;
    logic [PR_WIDTH-1:0]   pDest;
    logic [AR_WIDTH-1:0]   archDest;
    logic [ROB_WIDTH-1:0]  rob_idx;
  } loadStoreReservationEntry_t;

  typedef struct packed {
    logic                  cdb_valid;
    logic [PR_WIDTH-1:0]   phys_reg;
    logic [AR_WIDTH-1:0]   arch_reg;
    logic [ROB_WIDTH-1:0]  rob_idx;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

endpackage

// File: rtl/mem_fu_sequencer_ls_data_align.sv
// Byte-lane alignment for loads/stores: masks, shifted store data,
// extended load data and misalignment detection. Purely combinational.
module ls_data_align
  import rv32i_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [1:0]      b,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      rmask,
  output logic [3:0]      wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misalign
);

  logic [3:0]      mask;
  logic [XLEN-1:0] shifted;

  // Size decode (funct3[1:0]) to byte enables and alignment check
  always_comb begin
    mask     = 4'b1111;
    misalign = 1'b0;
    unique case (funct3[1:0])
      2'b00: mask = 4'b0001 << b;
      2'b01: begin
        mask     = 4'b0011 << b;
        misalign = b[0];
      end
      default: begin
        mask     = 4'b1111;
        misalign = (b != 2'b00);
      end
    endcase
  end

  assign rmask   = is_store ? 4'b0000 : mask;
  assign wmask   = is_store ? mask : 4'b0000;
  assign wdata   = rs2_val << {b, 3'b000};
  assign shifted = rdata >> {b, 3'b000};

  // Sign/zero extension of the lane-shifted read data
  always_comb begin
    load_data = shifted;
    unique case (funct3)
      LB:      load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LH:      load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LBU:     load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LHU:     load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_fu_sequencer.sv
// Memory FU sequencer: one outstanding dmem access, CDB broadcast for loads,
// store completion pulse for stores, flush-aware draining.
module mem_fu_sequencer
  import rv32i_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  loadStoreReservationEntry_t issue_entry,
  input  logic [XLEN-1:0]            rs1_val,
  input  logic [XLEN-1:0]            rs2_val,
  input  logic                       flush,
  output logic                       memory_fu_ready,
  output logic [XLEN-1:0]            dmem_addr,
  output logic [3:0]                 dmem_rmask,
  output logic [3:0]                 dmem_wmask,
  output logic [XLEN-1:0]            dmem_wdata,
  input  logic [XLEN-1:0]            dmem_rdata,
  input  logic                       dmem_resp,
  output cdb_t                       cdb_out,
  output logic                       store_done,
  output logic [ROB_WIDTH-1:0]       store_done_rob,
  output logic                       misalign
);

  mem_seq_state_t state_q, state_d;

  logic [XLEN-1:0]      ea_q, rs2_q, rdata_q;
  logic [2:0]           funct3_q;
  logic                 is_store_q, misalign_q;
  logic [PR_WIDTH-1:0]  pdest_q;
  logic [AR_WIDTH-1:0]  arch_q;
  logic [ROB_WIDTH-1:0] rob_q;

  logic [XLEN-1:0] ea_issue;
  logic            in_idle, req_active, accept, capture_rdata;
  logic [2:0]      al_funct3;
  logic            al_is_store, al_misalign;
  logic [1:0]      al_b;
  logic [XLEN-1:0] al_rs2, al_wdata, al_load_data;
  logic [3:0]      al_rmask, al_wmask;

  // Register-file source tags are consumed upstream by the regfile read
  logic unused_src_tags;
  assign unused_src_tags = ^{issue_entry.addr, issue_entry.data};

  assign ea_issue   = rs1_val + issue_entry.offset;
  assign in_idle    = (state_q == StIdle);
  assign req_active = (state_q == StAccess) || (state_q == StDrain);
  assign accept     = in_idle && issue_entry.ls_valid && !flush;
  assign capture_rdata = (state_q == StAccess) && dmem_resp && !flush;

  // Aligner sees the live issue in IDLE (for misalign detection) and the latched entry otherwise
  assign al_funct3   = in_idle ? issue_entry.funct3   : funct3_q;
  assign al_is_store = in_idle ? issue_entry.is_store : is_store_q;
  assign al_b        = in_idle ? ea_issue[1:0]        : ea_q[1:0];
  assign al_rs2      = in_idle ? rs2_val              : rs2_q;

  ls_data_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3    (al_funct3),
    .is_store  (al_is_store),
    .b         (al_b),
    .rs2_val   (al_rs2),
    .rdata     (rdata_q),
    .rmask     (al_rmask),
    .wmask     (al_wmask),
    .wdata     (al_wdata),
    .load_data (al_load_data),
    .misalign  (al_misalign)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = al_misalign ? StDone : StAccess;
      StAccess: begin
        if (flush)          state_d = dmem_resp ? StIdle : StDrain;
        else if (dmem_resp) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      StDrain:  if (dmem_resp) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Latch the issued entry on accept and the read data on a live response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q       <= '0;
      rs2_q      <= '0;
      rdata_q    <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      misalign_q <= 1'b0;
      pdest_q    <= '0;
      arch_q     <= '0;
      rob_q      <= '0;
    end else if (accept) begin
      ea_q       <= ea_issue;
      rs2_q      <= rs2_val;
      rdata_q    <= '0;
      funct3_q   <= issue_entry.funct3;
      is_store_q <= issue_entry.is_store;
      misalign_q <= al_misalign;
      pdest_q    <= issue_entry.pDest;
      arch_q     <= issue_entry.archDest;
      rob_q      <= issue_entry.rob_idx;
    end else if (capture_rdata) begin
      rdata_q    <= dmem_rdata;
    end
  end

  // Outputs: request only while ACCESS/DRAIN, completion only in DONE without flush
  always_comb begin
    memory_fu_ready = in_idle && !issue_entry.ls_valid && !flush;
    dmem_addr       = req_active ? {ea_q[XLEN-1:2], 2'b00} : '0;
    dmem_rmask      = req_active ? al_rmask : 4'b0000;
    dmem_wmask      = req_active ? al_wmask : 4'b0000;
    dmem_wdata      = req_active ? al_wdata : '0;
    cdb_out         = '0;
    store_done      = 1'b0;
    store_done_rob  = '0;
    misalign        = (state_q == StDone) && misalign_q;
    if ((state_q == StDone) && !flush) begin
      if (is_store_q) begin
        store_done     = 1'b1;
        store_done_rob = rob_q;
      end else begin
        cdb_out.cdb_valid = 1'b1;
        cdb_out.phys_reg  = pdest_q;
        cdb_out.arch_reg  = arch_q;
        cdb_out.rob_idx   = rob_q;
        cdb_out.data      = misalign_q ? '0 : al_load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_fu_sequencer.sv
// Directed self-checking bench for mem_fu_sequencer.
module tb_mem_fu_sequencer;
  import rv32i_types::*;

  logic                       clk;
  logic                       rst_n;
  loadStoreReservationEntry_t issue_entry;
  logic [31:0]                rs1_val, rs2_val;
  logic                       flush;
  logic                       memory_fu_ready;
  logic [31:0]                dmem_addr;
  logic [3:0]                 dmem_rmask, dmem_wmask;
  logic [31:0]                dmem_wdata, dmem_rdata;
  logic                       dmem_resp;
  cdb_t                       cdb_out;
  logic                       store_done;
  logic [ROB_WIDTH-1:0]       store_done_rob;
  logic                       misalign;

  int n_total = 0;
  int n_bad   = 0;

  mem_fu_sequencer #(
    .XLEN(32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_entry     (issue_entry),
    .rs1_val         (rs1_val),
    .rs2_val         (rs2_val),
    .flush           (flush),
    .memory_fu_ready (memory_fu_ready),
    .dmem_addr       (dmem_addr),
    .dmem_rmask      (dmem_rmask),
    .dmem_wmask      (dmem_wmask),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_resp       (dmem_resp),
    .cdb_out         (cdb_out),
    .store_done      (store_done),
    .store_done_rob  (store_done_rob),
    .misalign        (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic loadStoreReservationEntry_t mk(input logic st, input logic [2:0] f3,
      input logic [31:0] off, input logic [5:0] pd, input logic [4:0] ad, input logic [3:0] rob);
    loadStoreReservationEntry_t e;
    e          = '0;
    e.ls_valid = 1'b1;
    e.is_store = st;
    e.funct3   = f3;
    e.offset   = off;
    e.pDest    = pd;
    e.archDest = ad;
    e.rob_idx  = rob;
    return e;
  endfunction

  // Issue one aligned access, respond at cycle lat, check request and completion
  task automatic run_op(input string tag, input loadStoreReservationEntry_t e,
      input logic [31:0] rs1, input logic [31:0] rs2, input int lat, input logic [31:0] rdata,
      input logic [31:0] exp_addr, input logic [3:0] exp_rm, input logic [3:0] exp_wm,
      input logic [31:0] exp_wd, input logic [31:0] exp_data);
    issue_entry = e;
    rs1_val     = rs1;
    rs2_val     = rs2;
    #1;
    check({tag, ".ready_issue"}, 32'(memory_fu_ready), 32'd0);
    next_cycle();
    issue_entry = '0;
    rs1_val     = '0;
    rs2_val     = '0;
    #1;
    check({tag, ".addr"}, dmem_addr, exp_addr);
    check({tag, ".rmask"}, 32'(dmem_rmask), 32'(exp_rm));
    check({tag, ".wmask"}, 32'(dmem_wmask), 32'(exp_wm));
    check({tag, ".wdata"}, dmem_wdata, exp_wd);
    for (int i = 1; i < lat; i++) next_cycle();
    dmem_resp  = 1'b1;
    dmem_rdata = rdata;
    #1;
    check({tag, ".addr_hold"}, dmem_addr, exp_addr);
    next_cycle();
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    #1;
    check({tag, ".cdb_valid"}, 32'(cdb_out.cdb_valid), 32'(!e.is_store));
    check({tag, ".store_done"}, 32'(store_done), 32'(e.is_store));
    check({tag, ".rmask_done"}, 32'(dmem_rmask), 32'd0);
    if (e.is_store) begin
      check({tag, ".store_rob"}, 32'(store_done_rob), 32'(e.rob_idx));
    end else begin
      check({tag, ".data"}, cdb_out.data, exp_data);
      check({tag, ".phys"}, 32'(cdb_out.phys_reg), 32'(e.pDest));
      check({tag, ".arch"}, 32'(cdb_out.arch_reg), 32'(e.archDest));
      check({tag, ".rob"}, 32'(cdb_out.rob_idx), 32'(e.rob_idx));
    end
    next_cycle();
    check({tag, ".cdb_off"}, 32'(cdb_out.cdb_valid), 32'd0);
    check({tag, ".sd_off"}, 32'(store_done), 32'd0);
    check({tag, ".ready_back"}, 32'(memory_fu_ready), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    issue_entry = '0;
    rs1_val     = '0;
    rs2_val     = '0;
    flush       = 1'b0;
    dmem_rdata  = '0;
    dmem_resp   = 1'b0;
    #12;
    check("rst.rmask", 32'(dmem_rmask), 32'd0);
    check("rst.addr", dmem_addr, 32'd0);
    check("rst.cdb", 32'(cdb_out.cdb_valid), 32'd0);
    check("rst.sd", 32'(store_done), 32'd0);
    check("rst.mis", 32'(misalign), 32'd0);
    rst_n = 1'b1;
    next_cycle();
    check("rst.ready", 32'(memory_fu_ready), 32'd1);

    run_op("lw", mk(1'b0, LW, 32'd4, 6'd7, 5'd3, 4'd5), 32'h1000, 32'h0, 3, 32'hDEADBEEF,
           32'h1004, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF);
    run_op("lb", mk(1'b0, LB, 32'd3, 6'd8, 5'd4, 4'd1), 32'h2000, 32'h0, 1, 32'h80123456,
           32'h2000, 4'h8, 4'h0, 32'h0, 32'hFFFFFF80);
    run_op("lbu", mk(1'b0, LBU, 32'd3, 6'd9, 5'd0, 4'd2), 32'h2000, 32'h0, 1, 32'h80123456,
           32'h2000, 4'h8, 4'h0, 32'h0, 32'h00000080);
    run_op("sh", mk(1'b1, SH, 32'd2, 6'd0, 5'd0, 4'd6), 32'h3000, 32'h1234ABCD, 2, 32'h0,
           32'h3000, 4'h0, 4'hC, 32'hABCD0000, 32'h0);
    run_op("lh", mk(1'b0, LH, 32'd2, 6'd10, 5'd5, 4'd3), 32'h8000, 32'h0, 1, 32'hF00D1234,
           32'h8000, 4'hC, 4'h0, 32'h0, 32'hFFFFF00D);
    run_op("lhu", mk(1'b0, LHU, 32'd2, 6'd11, 5'd6, 4'd4), 32'h8000, 32'h0, 2, 32'hF00D1234,
           32'h8000, 4'hC, 4'h0, 32'h0, 32'h0000F00D);
    run_op("sb", mk(1'b1, SB, 32'd1, 6'd0, 5'd0, 4'd7), 32'h9000, 32'h000000AB, 1, 32'h0,
           32'h9000, 4'h0, 4'h2, 32'h0000AB00, 32'h0);
    // Offset wraps modulo 2^32
    run_op("wrap", mk(1'b0, LW, 32'hFFFFFFFC, 6'd12, 5'd7, 4'd8), 32'h00000010, 32'h0, 1,
           32'h0BADF00D, 32'h0000000C, 4'hF, 4'h0, 32'h0, 32'h0BADF00D);

    // Misaligned LW: no request, misalign + CDB with zero data one cycle after issue
    issue_entry = mk(1'b0, LW, 32'd1, 6'd13, 5'd9, 4'd10);
    rs1_val     = 32'h4000;
    #1;
    check("mis.ready_issue", 32'(memory_fu_ready), 32'd0);
    next_cycle();
    issue_entry = '0;
    #1;
    check("mis.pulse", 32'(misalign), 32'd1);
    check("mis.rmask", 32'(dmem_rmask), 32'd0);
    check("mis.cdb", 32'(cdb_out.cdb_valid), 32'd1);
    check("mis.data", cdb_out.data, 32'd0);
    check("mis.rob", 32'(cdb_out.rob_idx), 32'd10);
    next_cycle();
    check("mis.pulse_off", 32'(misalign), 32'd0);
    check("mis.ready_back", 32'(memory_fu_ready), 32'd1);

    // Misaligned SW: store_done instead of CDB
    issue_entry = mk(1'b1, SW, 32'd2, 6'd0, 5'd0, 4'd11);
    rs1_val     = 32'h4000;
    next_cycle();
    issue_entry = '0;
    #1;
    check("missw.pulse", 32'(misalign), 32'd1);
    check("missw.sd", 32'(store_done), 32'd1);
    check("missw.rob", 32'(store_done_rob), 32'd11);
    check("missw.cdb", 32'(cdb_out.cdb_valid), 32'd0);
    next_cycle();

    // Flush one cycle into a 5-cycle access: request held until resp, no CDB
    issue_entry = mk(1'b0, LW, 32'd0, 6'd14, 5'd1, 4'd12);
    rs1_val     = 32'h5000;
    next_cycle();
    issue_entry = '0;
    flush       = 1'b1;
    #1;
    check("fl.rmask_c1", 32'(dmem_rmask), 32'hF);
    next_cycle();
    flush = 1'b0;
    #1;
    check("fl.rmask_c2", 32'(dmem_rmask), 32'hF);
    check("fl.addr_c2", dmem_addr, 32'h5000);
    check("fl.ready_c2", 32'(memory_fu_ready), 32'd0);
    next_cycle();
    next_cycle();
    next_cycle();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h12345678;
    #1;
    check("fl.rmask_c5", 32'(dmem_rmask), 32'hF);
    check("fl.ready_c5", 32'(memory_fu_ready), 32'd0);
    next_cycle();
    dmem_resp = 1'b0;
    #1;
    check("fl.cdb", 32'(cdb_out.cdb_valid), 32'd0);
    check("fl.ready_c6", 32'(memory_fu_ready), 32'd1);
    check("fl.rmask_c6", 32'(dmem_rmask), 32'd0);

    // Flush in the issue cycle drops the entry
    issue_entry = mk(1'b0, LW, 32'd0, 6'd15, 5'd2, 4'd13);
    rs1_val     = 32'h5100;
    flush       = 1'b1;
    next_cycle();
    issue_entry = '0;
    flush       = 1'b0;
    #1;
    check("fli.rmask", 32'(dmem_rmask), 32'd0);
    check("fli.ready", 32'(memory_fu_ready), 32'd1);

    // Flush in DONE suppresses the CDB
    issue_entry = mk(1'b0, LW, 32'd0, 6'd16, 5'd3, 4'd14);
    rs1_val     = 32'h5200;
    next_cycle();
    issue_entry = '0;
    dmem_resp   = 1'b1;
    next_cycle();
    dmem_resp = 1'b0;
    flush     = 1'b1;
    #1;
    check("fld.cdb", 32'(cdb_out.cdb_valid), 32'd0);
    next_cycle();
    flush = 1'b0;

    // Back-to-back: second entry waits until the first completes
    issue_entry = mk(1'b0, LW, 32'd0, 6'd20, 5'd10, 4'd1);
    rs1_val     = 32'h6000;
    #1;
    check("b2b.ready_a", 32'(memory_fu_ready), 32'd0);
    next_cycle();
    issue_entry = mk(1'b0, LW, 32'd8, 6'd11, 5'd11, 4'd9);
    rs1_val     = 32'h7000;
    dmem_resp   = 1'b1;
    dmem_rdata  = 32'h11111111;
    #1;
    check("b2b.addr_a", dmem_addr, 32'h6000);
    next_cycle();
    dmem_resp = 1'b0;
    #1;
    check("b2b.data_a", cdb_out.data, 32'h11111111);
    check("b2b.rob_a", 32'(cdb_out.rob_idx), 32'd1);
    check("b2b.ready_done", 32'(memory_fu_ready), 32'd0);
    next_cycle();
    check("b2b.ready_idle", 32'(memory_fu_ready), 32'd0);
    check("b2b.rmask_idle", 32'(dmem_rmask), 32'd0);
    next_cycle();
    issue_entry = '0;
    dmem_resp   = 1'b1;
    dmem_rdata  = 32'h22222222;
    #1;
    check("b2b.addr_b", dmem_addr, 32'h7008);
    check("b2b.rmask_b", 32'(dmem_rmask), 32'hF);
    next_cycle();
    dmem_resp = 1'b0;
    #1;
    check("b2b.cdb_b", 32'(cdb_out.cdb_valid), 32'd1);
    check("b2b.data_b", cdb_out.data, 32'h22222222);
    check("b2b.rob_b", 32'(cdb_out.rob_idx), 32'd9);
    next_cycle();

    // Stray response in IDLE is ignored
    dmem_resp = 1'b1;
    next_cycle();
    dmem_resp = 1'b0;
    #1;
    check("stray.cdb", 32'(cdb_out.cdb_valid), 32'd0);
    check("stray.ready", 32'(memory_fu_ready), 32'd1);

    // Asynchronous reset mid-access
    issue_entry = mk(1'b0, LW, 32'd0, 6'd1, 5'd1, 4'd1);
    rs1_val     = 32'hA000;
    next_cycle();
    issue_entry = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.rmask", 32'(dmem_rmask), 32'd0);
    check("arst.addr", dmem_addr, 32'd0);
    rst_n = 1'b1;
    next_cycle();
    check("arst.ready", 32'(memory_fu_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
